poly_voice_mixer: RTL and testbench
===================================

Name: poly_voice_mixer

Overview:
Parametrised, time-multiplexed polyphonic mixer that replaces the fixed-width pre-division sum plus output divider stage.
- On each sample tick it snapshots all voice samples, on-flags and per-voice gains (MIDI velocity).
- It accumulates the weighted voices one per cycle, applies master attenuation and optional normalisation, then saturates.
- The result is presented on a valid/ready output toward the I2S transmitter.

Parameters:
NUM_VOICES, 4, number of voice inputs (>=1)
SAMPLE_WIDTH, 16, signed sample width in and out
GAIN_WIDTH, 7, unsigned per-voice gain width; full scale = 2^GAIN_WIDTH
ACC_WIDTH, 32, signed accumulator width; must be >= SAMPLE_WIDTH+GAIN_WIDTH+1+clog2(NUM_VOICES)

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous reset, active-high
sample_tick_in  input  1  one-cycle strobe: start a new mix frame
voice_on_in  input  NUM_VOICES  per-voice active flag
voice_gain_in  input  NUM_VOICES x GAIN_WIDTH  per-voice unsigned gain
voice_sample_in  input  NUM_VOICES x SAMPLE_WIDTH  per-voice signed sample
master_shift_in  input  3  extra arithmetic right shift (attenuation)
mix_out  output  SAMPLE_WIDTH  signed mixed sample
mix_valid_out  output  1  mix_out holds an unconsumed frame
mix_ready_in  input  1  downstream accepts frame
active_count_out  output  clog2(NUM_VOICES+1)  voices on in last snapshot
clip_out  output  1  one-cycle pulse when the current frame saturated
busy_out  output  1  high in any state other than IDLE
overrun_out  output  1  sticky: a tick was dropped

Behaviour:
- Reset (synchronous, rst_in high at clk_in edge):
  - State goes to IDLE.
  - mix_out, mix_valid_out, active_count_out, clip_out, busy_out and overrun_out are all 0.
  - The accumulator and snapshot registers are cleared.
  - Reset wins over every other event, including reset in the middle of a frame; the partial frame is discarded.
- States: IDLE, CAPTURE, ACCUM, SCALE, OUT.
- IDLE: when sample_tick_in is high, go to CAPTURE.
- CAPTURE (1 cycle):
  - Register all voice_*_in and master_shift_in.
  - Clear the accumulator.
  - Set the voice index to 0.
  - Compute the popcount of voice_on_in into active_count_out.
  - Go to ACCUM.
- ACCUM (NUM_VOICES cycles):
  - Each cycle: acc += on[idx] ? signed(sample[idx]) * unsigned(gain[idx]) : 0.
  - The product is signed, width SAMPLE_WIDTH+GAIN_WIDTH+1, sign-extended into acc.
  - idx wraps to 0 on the last voice; then go to SCALE.
- SCALE (1 cycle):
  - s = acc >>> (GAIN_WIDTH + shift + norm); arithmetic shift, floor rounding.
  - Saturate s to [-2^(SAMPLE_WIDTH-1), 2^(SAMPLE_WIDTH-1)-1] and register it to mix_out.
  - Pulse clip_out for one cycle if saturation occurred.
  - Go to OUT.
- OUT:
  - mix_valid_out is 1.
  - Hold mix_out stable until mix_valid_out && mix_ready_in; then clear valid and go to IDLE.
  - If sample_tick_in is high in the handshake cycle, go directly to CAPTURE; the tick is accepted and overrun is not flagged.
- Latency: a tick at cycle T gives mix_valid_out=1 at T+NUM_VOICES+3. With ready held high, the handshake completes in that same cycle.
- Dropped tick: a tick arriving while busy and not in the accepting OUT handshake cycle is ignored and sets overrun_out. overrun_out clears only on reset.
- mix_out retains the last frame after the handshake (for I2S hold).
- All voices off: acc=0, mix_out=0, active_count_out=0, frame is still produced.
- norm is 0 unless MIX_NORMALIZE_EN is defined.

Optional Feature:
MIX_NORMALIZE_EN
- Defined: norm = ceil(log2(active_count)) from the snapshot: 0 or 1 voices -> 0, 2 -> 1, 3-4 -> 2, 5-8 -> 3, and so on. Computed as a priority encoder in CAPTURE; no divider.
- Undefined: norm = 0; only master_shift_in attenuates.

Test Plan:
All scenarios use defaults and master_shift_in=0 unless stated.
1. Single voice: voice0 on, sample 0x1000, gain 64, others off; one tick with ready=1 -> mix_out=0x0800, active_count_out=1, clip_out=0, valid at T+7.
2. Positive saturation: all 4 voices on, sample 0x7FFF, gain 127 -> mix_out=0x7FFF, clip_out pulses once. With MIX_NORMALIZE_EN defined: mix_out=32511 (0x7EFF), no clip.
3. Negative saturation: all 4 voices on, sample 0x8000, gain 127 -> mix_out=0x8000, clip_out=1. With master_shift_in=7 and normalisation undefined: mix_out=-1016.
4. Backpressure: ready=0 for 20 cycles after valid, second tick arrives at cycle 10 of that wait -> mix_out and valid stable, overrun_out=1. Then raise ready while ticking in the same cycle -> new frame starts, and overrun_out stays 1 (sticky from the earlier drop; this accepted tick does not set it).
5. Off-voice masking: voice2 off with sample 0x7FFF gain 127, others on with sample 0 -> mix_out=0, active_count_out=3.
6. Reset mid-ACCUM: assert rst_in at cycle T+3 -> next cycle all outputs 0 and state IDLE. A following tick produces a correct frame unaffected by the partial accumulation.

Source files
------------

// File: rtl/poly_voice_mixer.sv
// poly_voice_mixer: time-multiplexed weighted mixer for NUM_VOICES voices.
// A sample tick snapshots all voice inputs; voices are multiply-accumulated
// one per cycle, then shifted down, saturated and offered on valid/ready.
// Optional build macro: MIX_NORMALIZE_EN adds a shift of
// ceil(log2(active voice count)) on top of master_shift_in.
module poly_voice_mixer #(
  parameter int NUM_VOICES   = 4,
  parameter int SAMPLE_WIDTH = 16,
  parameter int GAIN_WIDTH   = 7,
  parameter int ACC_WIDTH    = 32
) (
  input  logic                                 clk_in,
  input  logic                                 rst_in,
  input  logic                                 sample_tick_in,
  input  logic [NUM_VOICES-1:0]                voice_on_in,
  input  logic [NUM_VOICES*GAIN_WIDTH-1:0]     voice_gain_in,
  input  logic [NUM_VOICES*SAMPLE_WIDTH-1:0]   voice_sample_in,
  input  logic [2:0]                           master_shift_in,
  output logic [SAMPLE_WIDTH-1:0]              mix_out,
  output logic                                 mix_valid_out,
  input  logic                                 mix_ready_in,
  output logic [$clog2(NUM_VOICES+1)-1:0]      active_count_out,
  output logic                                 clip_out,
  output logic                                 busy_out,
  output logic                                 overrun_out
);

  localparam int CNT_W  = $clog2(NUM_VOICES + 1);
  localparam int IDX_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int PROD_W = SAMPLE_WIDTH + GAIN_WIDTH + 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CAPTURE = 3'd1;
  localparam logic [2:0] S_ACCUM   = 3'd2;
  localparam logic [2:0] S_SCALE   = 3'd3;
  localparam logic [2:0] S_OUT     = 3'd4;

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-SAMPLE_WIDTH+1){1'b0}}, {(SAMPLE_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-SAMPLE_WIDTH+1){1'b1}}, {(SAMPLE_WIDTH-1){1'b0}}};

  logic [2:0]                         state_q, state_d;
  logic [IDX_W-1:0]                   idx_q, idx_d;
  logic signed [ACC_WIDTH-1:0]        acc_q, acc_d;
  logic [NUM_VOICES-1:0]              on_q, on_d;
  logic [NUM_VOICES*GAIN_WIDTH-1:0]   gain_q, gain_d;
  logic [NUM_VOICES*SAMPLE_WIDTH-1:0] sample_q, sample_d;
  logic [2:0]                         shift_q, shift_d;
  logic [SAMPLE_WIDTH-1:0]            mix_q, mix_d;
  logic                               clip_q, clip_d;
  logic [CNT_W-1:0]                   cnt_q, cnt_d;
  logic                               overrun_q, overrun_d;

  logic [CNT_W-1:0]                   cnt_calc;
  logic                               on_sel;
  logic [GAIN_WIDTH-1:0]              gain_sel;
  logic [SAMPLE_WIDTH-1:0]            sample_sel;
  logic signed [PROD_W-1:0]           prod;
  logic [7:0]                         shamt;
  logic signed [ACC_WIDTH-1:0]        scaled;
  logic                               accept_tick;

`ifdef MIX_NORMALIZE_EN
  localparam int NORM_W = $clog2(CNT_W + 1);
  logic [NORM_W-1:0] norm_q, norm_d, norm_calc;
`endif

  // Next-state, datapath and status computation for the mix frame FSM.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    on_d      = on_q;
    gain_d    = gain_q;
    sample_d  = sample_q;
    shift_d   = shift_q;
    mix_d     = mix_q;
    clip_d    = 1'b0;
    cnt_d     = cnt_q;
    overrun_d = overrun_q;

    cnt_calc = '0;
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      cnt_calc = cnt_calc + CNT_W'(voice_on_in[v]);
    end

    on_sel     = 1'b0;
    gain_sel   = '0;
    sample_sel = '0;
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      if (idx_q == IDX_W'(v)) begin
        on_sel     = on_q[v];
        gain_sel   = gain_q[v*GAIN_WIDTH +: GAIN_WIDTH];
        sample_sel = sample_q[v*SAMPLE_WIDTH +: SAMPLE_WIDTH];
      end
    end
    prod = PROD_W'($signed(sample_sel)) * PROD_W'($signed({1'b0, gain_sel}));

`ifdef MIX_NORMALIZE_EN
    norm_d    = norm_q;
    // Smallest n with 2^n >= count, as a priority chain over thresholds.
    norm_calc = '0;
    for (int unsigned b = 0; b < CNT_W; b++) begin
      if (32'(cnt_calc) > (32'd1 << b)) norm_calc = NORM_W'(b + 1);
    end
    shamt = 8'(GAIN_WIDTH) + 8'(shift_q) + 8'(norm_q);
`else
    shamt = 8'(GAIN_WIDTH) + 8'(shift_q);
`endif
    scaled = acc_q >>> shamt;

    accept_tick = (state_q == S_IDLE) || ((state_q == S_OUT) && mix_ready_in);
    if (sample_tick_in && !accept_tick) overrun_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (sample_tick_in) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        on_d     = voice_on_in;
        gain_d   = voice_gain_in;
        sample_d = voice_sample_in;
        shift_d  = master_shift_in;
        cnt_d    = cnt_calc;
`ifdef MIX_NORMALIZE_EN
        norm_d   = norm_calc;
`endif
        acc_d    = '0;
        idx_d    = '0;
        state_d  = S_ACCUM;
      end
      S_ACCUM: begin
        if (on_sel) acc_d = acc_q + ACC_WIDTH'(prod);
        if (idx_q == IDX_W'(NUM_VOICES - 1)) begin
          idx_d   = '0;
          state_d = S_SCALE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_SCALE: begin
        if (scaled > SAT_MAX) begin
          mix_d  = SAT_MAX[SAMPLE_WIDTH-1:0];
          clip_d = 1'b1;
        end else if (scaled < SAT_MIN) begin
          mix_d  = SAT_MIN[SAMPLE_WIDTH-1:0];
          clip_d = 1'b1;
        end else begin
          mix_d  = scaled[SAMPLE_WIDTH-1:0];
        end
        state_d = S_OUT;
      end
      S_OUT: begin
        if (mix_ready_in) state_d = sample_tick_in ? S_CAPTURE : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      acc_q     <= '0;
      on_q      <= '0;
      gain_q    <= '0;
      sample_q  <= '0;
      shift_q   <= '0;
      mix_q     <= '0;
      clip_q    <= 1'b0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
`ifdef MIX_NORMALIZE_EN
      norm_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      on_q      <= on_d;
      gain_q    <= gain_d;
      sample_q  <= sample_d;
      shift_q   <= shift_d;
      mix_q     <= mix_d;
      clip_q    <= clip_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
`ifdef MIX_NORMALIZE_EN
      norm_q    <= norm_d;
`endif
    end
  end

  assign mix_out          = mix_q;
  assign mix_valid_out    = (state_q == S_OUT);
  assign active_count_out = cnt_q;
  assign clip_out         = clip_q;
  assign busy_out         = (state_q != S_IDLE);
  assign overrun_out      = overrun_q;

endmodule

// File: tb/tb_poly_voice_mixer.sv
// Testbench for poly_voice_mixer: directed vector table, random frames
// against an arithmetic reference model, and backpressure / reset sequences.
module tb_poly_voice_mixer;

  localparam int NV = 4;
  localparam int SW = 16;
  localparam int GW = 7;
  localparam int LAT = NV + 3;

  logic               clk = 1'b0;
  logic               rst;
  logic               tick;
  logic [NV-1:0]      von;
  logic [NV*GW-1:0]   vg;
  logic [NV*SW-1:0]   vs;
  logic [2:0]         msh;
  logic [SW-1:0]      mix;
  logic               valid;
  logic               ready;
  logic [2:0]         cnt;
  logic               clip;
  logic               busy;
  logic               ovr;

  int n_cmp = 0;
  int n_bad = 0;

  poly_voice_mixer #(
    .NUM_VOICES(NV),
    .SAMPLE_WIDTH(SW),
    .GAIN_WIDTH(GW),
    .ACC_WIDTH(32)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .sample_tick_in(tick),
    .voice_on_in(von),
    .voice_gain_in(vg),
    .voice_sample_in(vs),
    .master_shift_in(msh),
    .mix_out(mix),
    .mix_valid_out(valid),
    .mix_ready_in(ready),
    .active_count_out(cnt),
    .clip_out(clip),
    .busy_out(busy),
    .overrun_out(ovr)
  );

  always #5 clk = ~clk;

  typedef struct {
    string          name;
    logic [NV-1:0]  on;
    logic [NV*GW-1:0] g;
    logic [NV*SW-1:0] s;
    logic [2:0]     sh;
    int             exp_mix;
    int             exp_clip;
    int             exp_cnt;
  } vec_t;

  vec_t tbl[11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [NV*GW-1:0] pg(int a, int b, int c, int d);
    return {7'(d), 7'(c), 7'(b), 7'(a)};
  endfunction

  function automatic logic [NV*SW-1:0] ps(int a, int b, int c, int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  // Reference: weighted sum, floor-divide by a power of two, clamp.
  function automatic longint model(input logic [NV-1:0] on, input logic [NV*GW-1:0] g,
                                   input logic [NV*SW-1:0] s, input logic [2:0] sh,
                                   output int clipped);
    longint sum = 0;
    longint r;
    int nact = 0;
    int nrm = 0;
    for (int i = 0; i < NV; i++) begin
      if (on[i]) begin
        sum += longint'($signed(s[i*SW +: SW])) * longint'(g[i*GW +: GW]);
        nact++;
      end
    end
`ifdef MIX_NORMALIZE_EN
    while ((1 << nrm) < nact) nrm++;
`endif
    r = sum >>> (GW + int'(sh) + nrm);
    clipped = 0;
    if (r > 32767) begin r = 32767; clipped = 1; end
    if (r < -32768) begin r = -32768; clipped = 1; end
    return r;
  endfunction

  task automatic set_vec(input int i, input string nm, input logic [NV-1:0] on,
                         input logic [NV*GW-1:0] g, input logic [NV*SW-1:0] s,
                         input logic [2:0] sh, input int m_def, input int m_norm,
                         input int c_def, input int c_norm, input int n);
    tbl[i].name = nm; tbl[i].on = on; tbl[i].g = g; tbl[i].s = s; tbl[i].sh = sh;
`ifdef MIX_NORMALIZE_EN
    tbl[i].exp_mix = m_norm; tbl[i].exp_clip = c_norm;
`else
    tbl[i].exp_mix = m_def; tbl[i].exp_clip = c_def;
`endif
    tbl[i].exp_cnt = n;
  endtask

  // Tick one frame with ready held high; returns observed results.
  task automatic run_frame(input logic [NV-1:0] on, input logic [NV*GW-1:0] g,
                           input logic [NV*SW-1:0] s, input logic [2:0] sh,
                           output longint m, output int clips, output int c,
                           output int lat);
    von = on; vg = g; vs = s; msh = sh; ready = 1'b1; tick = 1'b1;
    step();
    tick = 1'b0;
    lat = 1;
    clips = clip ? 1 : 0;
    while (!valid && lat < 50) begin
      step();
      lat++;
      if (clip) clips++;
    end
    m = longint'($signed(mix));
    c = int'(cnt);
    step();
    if (clip) clips++;
    check("valid_after_handshake", longint'(valid), 0);
    check("mix_hold_after_handshake", longint'($signed(mix)), m);
  endtask

  initial begin
    longint m, em, m0;
    int clips, c, lat, eclip;

    rst = 1'b1; tick = 1'b0; ready = 1'b0; von = '0; vg = '0; vs = '0; msh = '0;
    repeat (3) step();
    rst = 1'b0;
    step();
    check("reset_mix", longint'(mix), 0);
    check("reset_valid", longint'(valid), 0);
    check("reset_count", longint'(cnt), 0);
    check("reset_clip", longint'(clip), 0);
    check("reset_busy", longint'(busy), 0);
    check("reset_overrun", longint'(ovr), 0);

    set_vec(0, "single_voice", 4'b0001, pg(64,0,0,0), ps('h1000,0,0,0), 3'd0,
            2048, 2048, 0, 0, 1);
    set_vec(1, "pos_sat", 4'b1111, pg(127,127,127,127), ps('h7FFF,'h7FFF,'h7FFF,'h7FFF), 3'd0,
            32767, 32511, 1, 0, 4);
    set_vec(2, "neg_sat", 4'b1111, pg(127,127,127,127), ps('h8000,'h8000,'h8000,'h8000), 3'd0,
            -32768, -32512, 1, 0, 4);
    set_vec(3, "neg_shift7", 4'b1111, pg(127,127,127,127), ps('h8000,'h8000,'h8000,'h8000), 3'd7,
            -1016, -254, 0, 0, 4);
    set_vec(4, "off_mask", 4'b1011, pg(127,127,127,127), ps(0,0,'h7FFF,0), 3'd0,
            0, 0, 0, 0, 3);
    set_vec(5, "all_off", 4'b0000, pg(127,127,127,127), ps('h7FFF,'h7FFF,'h7FFF,'h7FFF), 3'd0,
            0, 0, 0, 0, 0);
    set_vec(6, "floor_neg", 4'b0001, pg(1,0,0,0), ps('hFFFF,0,0,0), 3'd0,
            -1, -1, 0, 0, 1);
    set_vec(7, "exact_max", 4'b0011, pg(127,1,0,0), ps('h7FFF,'h7FFF,0,0), 3'd0,
            32767, 16383, 0, 0, 2);
    set_vec(8, "max_plus_one", 4'b0111, pg(127,1,1,0), ps('h7FFF,'h7FFF,'h0080,0), 3'd0,
            32767, 8192, 1, 0, 3);
    set_vec(9, "exact_min", 4'b0011, pg(127,1,0,0), ps('h8000,'h8000,0,0), 3'd0,
            -32768, -16384, 0, 0, 2);
    set_vec(10, "master_shift3", 4'b0001, pg(127,0,0,0), ps('h4000,0,0,0), 3'd3,
            2032, 2032, 0, 0, 1);

    for (int i = 0; i < 11; i++) begin
      run_frame(tbl[i].on, tbl[i].g, tbl[i].s, tbl[i].sh, m, clips, c, lat);
      check({tbl[i].name, "_mix"}, m, tbl[i].exp_mix);
      check({tbl[i].name, "_clip"}, clips, tbl[i].exp_clip);
      check({tbl[i].name, "_count"}, c, tbl[i].exp_cnt);
      check({tbl[i].name, "_latency"}, lat, LAT);
    end

    for (int r = 0; r < 40; r++) begin
      logic [NV-1:0] ron;
      logic [NV*GW-1:0] rg;
      logic [NV*SW-1:0] rs;
      logic [2:0] rsh;
      int ncnt;
      ron = 4'($urandom);
      rg  = {$urandom, $urandom} & {(NV*GW){1'b1}};
      rs  = {$urandom, $urandom};
      rsh = 3'($urandom_range(0, 7));
      em  = model(ron, rg, rs, rsh, eclip);
      ncnt = $countones(ron);
      run_frame(ron, rg, rs, rsh, m, clips, c, lat);
      check("rand_mix", m, em);
      check("rand_clip", clips, eclip);
      check("rand_count", c, ncnt);
      check("rand_latency", lat, LAT);
    end
    check("no_overrun_yet", longint'(ovr), 0);

    // Backpressure with a dropped tick, then an accepted tick on handshake.
    von = 4'b0001; vg = pg(64,0,0,0); vs = ps('h1000,0,0,0); msh = 3'd0;
    ready = 1'b0; tick = 1'b1;
    step();
    tick = 1'b0;
    lat = 1;
    while (!valid && lat < 50) begin step(); lat++; end
    check("bp_latency", lat, LAT);
    m0 = longint'($signed(mix));
    check("bp_mix", m0, 2048);
    for (int k = 1; k <= 20; k++) begin
      if (k == 10) tick = 1'b1;
      step();
      tick = 1'b0;
      check("bp_valid_stable", longint'(valid), 1);
      check("bp_mix_stable", longint'($signed(mix)), m0);
      if (k == 9)  check("bp_overrun_before", longint'(ovr), 0);
      if (k == 10) check("bp_overrun_set", longint'(ovr), 1);
    end
    von = 4'b0010; vg = pg(0,32,0,0); vs = ps(0,'hF000,0,0);
    ready = 1'b1; tick = 1'b1;
    step();
    tick = 1'b0;
    check("accept_valid_cleared", longint'(valid), 0);
    check("accept_busy", longint'(busy), 1);
    check("accept_overrun_sticky", longint'(ovr), 1);
    lat = 1;
    while (!valid && lat < 50) begin step(); lat++; end
    check("accept_latency", lat, LAT);
    check("accept_mix", longint'($signed(mix)), -1024);
    check("accept_count", longint'(cnt), 1);
    step();
    check("overrun_still_sticky", longint'(ovr), 1);

    // Reset in the middle of accumulation.
    von = 4'b1111; vg = pg(10,10,10,10); vs = ps('h0100,'h0100,'h0100,'h0100);
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    check("midrst_mix", longint'(mix), 0);
    check("midrst_valid", longint'(valid), 0);
    check("midrst_count", longint'(cnt), 0);
    check("midrst_clip", longint'(clip), 0);
    check("midrst_busy", longint'(busy), 0);
    check("midrst_overrun", longint'(ovr), 0);
    rst = 1'b0;
    step();
    run_frame(4'b1000, pg(0,0,0,127), ps(0,0,0,'h0200), 3'd0, m, clips, c, lat);
    check("post_rst_mix", m, 508);
    check("post_rst_count", c, 1);
    check("post_rst_clip", clips, 0);
    check("post_rst_latency", lat, LAT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
